// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle scheduler: FSM state encoding and
// the full-scale percent constant.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SYNC,
        ST_HIGH,
        ST_LOW,
        ST_DIVIDE,
        ST_OUTPUT
    } pwm_state_e;

    localparam logic [7:0] PCT_FULL = 8'd100;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider producing an 8-bit quotient.
// 'done' pulses exactly CNT_W+7 cycles after 'start'.
module pwm_duty_div #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W+6:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [7:0]       quotient
);
    localparam int DVD_W  = CNT_W + 7;
    localparam int STEP_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0]  q_sh;
    logic [CNT_W-1:0]  rem;
    logic [STEP_W-1:0] steps;
    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    diff;
    logic              running;

    // The dividend register doubles as the quotient register: one bit shifts
    // out into the remainder while one quotient bit shifts in.
    assign trial    = {rem, q_sh[DVD_W-1]};
    assign diff     = trial - {1'b0, divisor};
    assign quotient = q_sh[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sh    <= '0;
            rem     <= '0;
            steps   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q_sh    <= dividend;
                rem     <= '0;
                steps   <= STEP_W'(DVD_W);
                running <= 1'b1;
            end else if (running) begin
                if (!diff[CNT_W]) begin
                    rem  <= diff[CNT_W-1:0];
                    q_sh <= {q_sh[DVD_W-2:0], 1'b1};
                end else begin
                    rem  <= trial[CNT_W-1:0];
                    q_sh <= {q_sh[DVD_W-2:0], 1'b0};
                end
                steps <= steps - STEP_W'(1);
                if (steps == STEP_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Round-robin PWM duty-cycle meter: picks the next enabled channel, times one
// high/low period with a watchdog, divides to percent and hands the result out.
module pwm_duty_scheduler
    import pwm_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NCH-1:0]         ch_mask,
    input  logic [NCH-1:0]         pwm_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic [7:0]             res_duty,
    output logic                   res_timeout,
    output logic                   busy
);
    localparam int CH_W  = $clog2(NCH);
    localparam int DVD_W = CNT_W + 7;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    pwm_state_e        state;
    logic [NCH-1:0]    sync1, sync2, sync_d;
    logic [CH_W-1:0]   sel_ch, last_ch, nxt_ch;
    logic              mask_hit;
    logic [CNT_W-1:0]  high_cnt, per_cnt, wd_cnt;
    logic              cur, rise;
    logic              div_start, div_done;
    logic [7:0]        div_q;
    logic [DVD_W-1:0]  dividend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
        end else begin
            sync1  <= pwm_in;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign cur  = sync2[sel_ch];
    assign rise = sync2[sel_ch] & ~sync_d[sel_ch];

    // Scan downward so the closest set bit after last_ch is assigned last.
    always_comb begin
        nxt_ch   = last_ch;
        mask_hit = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            if (ch_mask[CH_W'((int'(last_ch) + i) % NCH)]) begin
                nxt_ch   = CH_W'((int'(last_ch) + i) % NCH);
                mask_hit = 1'b1;
            end
        end
    end

    assign dividend = DVD_W'(high_cnt) * DVD_W'(PCT_FULL);

    pwm_duty_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(dividend),
        .divisor (per_cnt),
        .done    (div_done),
        .quotient(div_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            sel_ch      <= '0;
            last_ch     <= CH_W'(NCH - 1);
            high_cnt    <= '0;
            per_cnt     <= '0;
            wd_cnt      <= '0;
            div_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_duty    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && ch_mask != '0) begin
                        state <= ST_SELECT;
                        busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (mask_hit) begin
                        sel_ch  <= nxt_ch;
                        last_ch <= nxt_ch;
                        wd_cnt  <= '0;
                        state   <= ST_SYNC;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SYNC, ST_HIGH, ST_LOW: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        state       <= ST_OUTPUT;
                        res_valid   <= 1'b1;
                        res_ch      <= sel_ch;
                        res_timeout <= 1'b1;
                        res_duty    <= cur ? PCT_FULL : 8'd0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        case (state)
                            ST_SYNC: begin
                                if (rise) begin
                                    high_cnt <= CNT_W'(1);
                                    per_cnt  <= CNT_W'(1);
                                    state    <= ST_HIGH;
                                end
                            end
                            ST_HIGH: begin
                                per_cnt <= per_cnt + CNT_W'(1);
                                if (cur) high_cnt <= high_cnt + CNT_W'(1);
                                else     state    <= ST_LOW;
                            end
                            ST_LOW: begin
                                if (rise) begin
                                    state     <= ST_DIVIDE;
                                    div_start <= 1'b1;
                                end else begin
                                    per_cnt <= per_cnt + CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        state       <= ST_OUTPUT;
                        res_valid   <= 1'b1;
                        res_ch      <= sel_ch;
                        res_timeout <= 1'b0;
                        res_duty    <= div_q;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (enable) begin
                            state <= ST_SELECT;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Scoreboard bench for pwm_duty_scheduler: PWM generators on every channel,
// expected results queued per stimulus and checked on each handshake.
module tb_pwm_duty_scheduler;
    localparam int NCH         = 4;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [NCH-1:0] ch_mask;
    logic [NCH-1:0] pwm_in;
    logic           res_valid;
    logic           res_ready;
    logic [1:0]     res_ch;
    logic [7:0]     res_duty;
    logic           res_timeout;
    logic           busy;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] duty;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   hi_len[NCH];
    int   lo_len[NCH];
    int   mode[NCH];
    int   cyc;

    always #5 clk = ~clk;

    pwm_duty_scheduler #(
        .NCH(NCH), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .pwm_in(pwm_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_duty(res_duty), .res_timeout(res_timeout), .busy(busy)
    );

    // mode 0: toggle hi_len/lo_len, mode 1: held high, mode 2: held low
    initial begin
        pwm_in = '0;
        cyc    = 0;
        forever begin
            @(posedge clk);
            #3;
            cyc++;
            for (int c = 0; c < NCH; c++) begin
                if (mode[c] == 1)
                    pwm_in[c] = 1'b1;
                else if (mode[c] == 0 && hi_len[c] > 0)
                    pwm_in[c] = ((cyc % (hi_len[c] + lo_len[c])) < hi_len[c]);
                else
                    pwm_in[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: got ch=%0d duty=%0d timeout=%0d, required none",
                         res_ch, res_duty, res_timeout);
            end else begin
                e = sb.pop_front();
                total_cnt++;
                if (res_ch !== e.ch)
                    $display("FAIL res_ch: got %0d required %0d", res_ch, e.ch);
                else pass_cnt++;
                total_cnt++;
                if (res_duty !== e.duty)
                    $display("FAIL res_duty: got %0d required %0d", res_duty, e.duty);
                else pass_cnt++;
                total_cnt++;
                if (res_timeout !== e.to)
                    $display("FAIL res_timeout: got %0d required %0d", res_timeout, e.to);
                else pass_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int ch, input int duty, input bit to);
        exp_t e;
        e.ch   = 2'(ch);
        e.duty = 8'(duty);
        e.to   = to;
        sb.push_back(e);
    endtask

    task automatic set_pat(input int ch, input int m, input int h, input int l);
        mode[ch]   = m;
        hi_len[ch] = h;
        lo_len[ch] = l;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        total_cnt++;
        if (res_valid !== 1'b1)
            $display("FAIL %s: res_valid=%0b after %0d cycles, required 1", name, res_valid, n);
        else pass_cnt++;
    endtask

    task automatic finish_one();
        enable    = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        res_ready = 1'b0;
        ch_mask   = '0;
        repeat (3) step();
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL rst_valid: got %0b required 0", res_valid); else pass_cnt++;
        total_cnt++; if (res_ch !== 2'd0) $display("FAIL rst_ch: got %0d required 0", res_ch); else pass_cnt++;
        total_cnt++; if (res_duty !== 8'd0) $display("FAIL rst_duty: got %0d required 0", res_duty); else pass_cnt++;
        total_cnt++; if (res_timeout !== 1'b0) $display("FAIL rst_timeout: got %0b required 0", res_timeout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b required 0", busy); else pass_cnt++;
        rst = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        int n;
        set_pat(0, 0, 5, 5);
        set_pat(1, 0, 4, 6);
        set_pat(2, 0, 2, 8);
        set_pat(3, 0, 3, 7);
        repeat (5) step();
        ch_mask = 4'b0101;
        push_exp(0, 50, 0);
        push_exp(2, 20, 0);
        push_exp(0, 50, 0);
        push_exp(2, 20, 0);
        res_ready = 1'b1;
        enable    = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            step();
            n++;
        end
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL rr_drain: %0d results outstanding after %0d cycles, required 0", sb.size(), n);
        else pass_cnt++;
        enable = 1'b0;
        repeat (30) step();
        res_ready = 1'b0;
    endtask

    task automatic test_duty();
        int h[3] = '{5, 3, 1};
        int l[3] = '{5, 7, 9};
        ch_mask = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_pat(0, 0, h[k], l[k]);
            repeat (5) step();
            push_exp(0, (h[k] * 100) / (h[k] + l[k]), 0);
            res_ready = 1'b0;
            enable    = 1'b1;
            wait_valid(200, "duty_valid");
            finish_one();
        end
    endtask

    task automatic test_mask_change();
        set_pat(0, 0, 3, 7);
        set_pat(1, 0, 8, 2);
        ch_mask = 4'b0001;
        repeat (5) step();
        push_exp(0, 30, 0);
        res_ready = 1'b0;
        enable    = 1'b1;
        repeat (4) step();
        ch_mask = 4'b0010;
        wait_valid(200, "mask_valid");
        finish_one();
    endtask

    task automatic test_timeout();
        int n;
        set_pat(0, 2, 0, 0);
        ch_mask = 4'b0001;
        repeat (6) step();
        push_exp(0, 0, 1);
        res_ready = 1'b0;
        enable    = 1'b1;
        n = 0;
        while (res_valid !== 1'b1 && n < TIMEOUT_CYC + 50) begin
            step();
            n++;
        end
        total_cnt++;
        if (n != TIMEOUT_CYC + 2)
            $display("FAIL timeout_latency: valid after %0d cycles, required %0d", n, TIMEOUT_CYC + 2);
        else pass_cnt++;
        finish_one();
        set_pat(0, 1, 0, 0);
        repeat (6) step();
        push_exp(0, 100, 1);
        res_ready = 1'b0;
        enable    = 1'b1;
        wait_valid(TIMEOUT_CYC + 50, "timeout_high_valid");
        finish_one();
    endtask

    task automatic test_backpressure();
        set_pat(0, 0, 5, 5);
        ch_mask = 4'b0001;
        repeat (5) step();
        push_exp(0, 50, 0);
        res_ready = 1'b0;
        enable    = 1'b1;
        wait_valid(200, "bp_valid");
        for (int k = 0; k < 20; k++) begin
            step();
            total_cnt++;
            if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_duty !== 8'd50 || res_timeout !== 1'b0 || busy !== 1'b1)
                $display("FAIL bp_hold: cycle %0d valid=%0b ch=%0d duty=%0d to=%0b busy=%0b, required 1/0/50/0/1",
                         k, res_valid, res_ch, res_duty, res_timeout, busy);
            else pass_cnt++;
        end
        finish_one();
    endtask

    task automatic test_reset_mid();
        int n;
        set_pat(0, 0, 7, 13);
        set_pat(2, 0, 2, 8);
        ch_mask = 4'b0001;
        repeat (5) step();
        res_ready = 1'b0;
        enable    = 1'b1;
        repeat (3) step();
        n = 0;
        while (pwm_in[0] !== 1'b0 && n < 100) begin step(); n++; end
        while (pwm_in[0] !== 1'b1 && n < 100) begin step(); n++; end
        total_cnt++;
        if (n >= 100) $display("FAIL mid_edge_wait: no rising edge within %0d cycles", n);
        else pass_cnt++;
        repeat (5) step();
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy: got %0b required 1", busy); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b required 0", busy); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b required 0", res_valid); else pass_cnt++;
        total_cnt++; if (res_duty !== 8'd0) $display("FAIL mid_rst_duty: got %0d required 0", res_duty); else pass_cnt++;
        total_cnt++; if (res_ch !== 2'd0) $display("FAIL mid_rst_ch: got %0d required 0", res_ch); else pass_cnt++;
        total_cnt++; if (res_timeout !== 1'b0) $display("FAIL mid_rst_timeout: got %0b required 0", res_timeout); else pass_cnt++;
        enable = 1'b0;
        repeat (2) step();
        ch_mask = 4'b0101;
        rst     = 1'b1;
        repeat (3) step();
        push_exp(0, 35, 0);
        enable = 1'b1;
        wait_valid(200, "mid_after_valid");
        finish_one();
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        res_ready = 1'b0;
        ch_mask   = '0;
        for (int c = 0; c < NCH; c++) set_pat(c, 2, 0, 0);
        test_reset();
        test_round_robin();
        test_duty();
        test_mask_change();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        repeat (5) step();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_empty: %0d results never produced, required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
